writeback_unit: RTL and testbench

WRITEBACK_UNIT -- requirements
Module: writeback_unit

---
 rtl/wb_pkg.sv | 16 +
 rtl/wb_scoreboard.sv | 48 ++++
 rtl/writeback_unit.sv | 162 ++++++++++++++++
 tb/tb_writeback_unit.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the writeback unit: default sizes, register-index
// type and the load-tracking FSM state encoding.
package wb_pkg;

   localparam int unsigned XLEN_DEF  = 32;
   localparam int unsigned NREGS_DEF = 32;
   localparam int unsigned REG_IDX_W = $clog2(NREGS_DEF);

   typedef logic [REG_IDX_W-1:0] reg_idx_t;

   typedef enum logic [0:0] {
      LD_IDLE = 1'b0,
      LD_WAIT = 1'b1
   } ld_state_e;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-load scoreboard: one bit per architectural register, marking the
// destination of the outstanding load. x0 is never marked. A set and a clear
// of the same index in one cycle leaves the bit set (new load replaces old).
module wb_scoreboard
   import wb_pkg::*;
#(
   parameter int unsigned NREGS = NREGS_DEF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_set_en,
   input  logic [$clog2(NREGS)-1:0] i_set_idx,
   input  logic                     i_clr_en,
   input  logic [$clog2(NREGS)-1:0] i_clr_idx,
   input  logic [$clog2(NREGS)-1:0] i_rd_idx1,
   input  logic [$clog2(NREGS)-1:0] i_rd_idx2,
   input  logic                     i_waw_en,
   input  logic [$clog2(NREGS)-1:0] i_waw_idx,
   output logic                     o_pend1,
   output logic                     o_pend2,
   output logic                     o_waw_hit
);

   logic [NREGS-1:0] r_pend;
   logic [NREGS-1:0] w_pend_nxt;

   // Clear first, then set, so a same-index set wins over the clear.
   always_comb begin
      w_pend_nxt = r_pend;
      if (i_clr_en)
         w_pend_nxt[i_clr_idx] = 1'b0;
      if (i_set_en && (i_set_idx != '0))
         w_pend_nxt[i_set_idx] = 1'b1;
   end

   // Pending-bit register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset)
         r_pend <= '0;
      else
         r_pend <= w_pend_nxt;
   end

   assign o_pend1   = (i_rd_idx1 != '0) && r_pend[i_rd_idx1];
   assign o_pend2   = (i_rd_idx2 != '0) && r_pend[i_rd_idx2];
   assign o_waw_hit = i_waw_en && (i_waw_idx != '0) && r_pend[i_waw_idx];

endmodule

// File: rtl/writeback_unit.sv
// Writeback unit: merges the single-cycle ALU result and the load-response
// handshake into one registered register-file write port, tracks the single
// outstanding load and raises decode stall on hazards.
// Optional feature macro: WB_FORWARD_EN (adds write-port forwarding outputs
// that replace the stall for an in-flight write match).
module writeback_unit
   import wb_pkg::*;
#(
   parameter int unsigned XLEN  = XLEN_DEF,
   parameter int unsigned NREGS = NREGS_DEF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     alu_valid,
   input  logic [$clog2(NREGS)-1:0] alu_rd,
   input  logic [XLEN-1:0]          alu_data,
   input  logic                     ld_issue,
   input  logic [$clog2(NREGS)-1:0] ld_issue_rd,
   input  logic                     ld_valid,
   output logic                     ld_ready,
   input  logic [XLEN-1:0]          ld_data,
   input  logic [$clog2(NREGS)-1:0] rs1,
   input  logic [$clog2(NREGS)-1:0] rs2,
   output logic                     stall,
   output logic                     ld_busy,
   output logic                     ld_spurious,
   output logic                     rf_we,
   output logic [$clog2(NREGS)-1:0] rf_waddr,
   output logic [XLEN-1:0]          rf_wdata
`ifdef WB_FORWARD_EN
   ,
   output logic                     fwd1_hit,
   output logic                     fwd2_hit,
   output logic [XLEN-1:0]          fwd_data
`endif
);

   localparam int unsigned IW = $clog2(NREGS);

   ld_state_e         r_state;
   ld_state_e         w_state_nxt;
   logic [IW-1:0]     r_ld_rd;
   logic              r_spurious;
   logic              r_we;
   logic [IW-1:0]     r_waddr;
   logic [XLEN-1:0]   r_wdata;

   logic              w_ld_acc;
   logic              w_ld_take;
   logic              w_issue_take;
   logic              w_pend1;
   logic              w_pend2;
   logic              w_waw;
   logic              w_m1;
   logic              w_m2;

   assign ld_ready  = !alu_valid;
   assign w_ld_acc  = ld_valid && ld_ready;
   assign w_ld_take = w_ld_acc && (r_state == LD_WAIT);

   // Load FSM next state; an issue is only taken from IDLE or alongside an
   // accepted response, otherwise it is dropped.
   always_comb begin
      w_state_nxt  = r_state;
      w_issue_take = 1'b0;
      unique case (r_state)
         LD_IDLE: begin
            if (ld_issue) begin
               w_state_nxt  = LD_WAIT;
               w_issue_take = 1'b1;
            end
         end
         LD_WAIT: begin
            if (w_ld_acc) begin
               if (ld_issue) begin
                  w_state_nxt  = LD_WAIT;
                  w_issue_take = 1'b1;
               end else begin
                  w_state_nxt  = LD_IDLE;
               end
            end
         end
         default: w_state_nxt = LD_IDLE;
      endcase
   end

   // Load FSM state and latched load destination.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= LD_IDLE;
         r_ld_rd <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_issue_take)
            r_ld_rd <= ld_issue_rd;
      end
   end

   // Registered write port: ALU first, then an accepted load for the latched rd.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_we    <= 1'b0;
         r_waddr <= '0;
         r_wdata <= '0;
      end else if (alu_valid) begin
         r_we    <= (alu_rd != '0);
         r_waddr <= alu_rd;
         r_wdata <= alu_data;
      end else if (w_ld_take) begin
         r_we    <= (r_ld_rd != '0);
         r_waddr <= r_ld_rd;
         r_wdata <= ld_data;
      end else begin
         r_we    <= 1'b0;
      end
   end

   // Sticky flag for a response consumed while no load was outstanding.
   always_ff @(posedge clk) begin
      if (reset)
         r_spurious <= 1'b0;
      else if (w_ld_acc && (r_state == LD_IDLE))
         r_spurious <= 1'b1;
   end

   wb_scoreboard #(
      .NREGS (NREGS)
   ) u_scoreboard (
      .clk       (clk),
      .reset     (reset),
      .i_set_en  (w_issue_take),
      .i_set_idx (ld_issue_rd),
      .i_clr_en  (w_ld_take),
      .i_clr_idx (r_ld_rd),
      .i_rd_idx1 (rs1),
      .i_rd_idx2 (rs2),
      .i_waw_en  (alu_valid),
      .i_waw_idx (alu_rd),
      .o_pend1   (w_pend1),
      .o_pend2   (w_pend2),
      .o_waw_hit (w_waw)
   );

   assign w_m1 = r_we && (rs1 != '0) && (r_waddr == rs1);
   assign w_m2 = r_we && (rs2 != '0) && (r_waddr == rs2);

`ifdef WB_FORWARD_EN
   assign fwd1_hit = w_m1;
   assign fwd2_hit = w_m2;
   assign fwd_data = r_wdata;
   assign stall    = w_pend1 || w_pend2 || w_waw;
`else
   assign stall    = w_pend1 || w_pend2 || w_waw || w_m1 || w_m2;
`endif

   assign ld_busy     = (r_state == LD_WAIT);
   assign ld_spurious = r_spurious;
   assign rf_we       = r_we;
   assign rf_waddr    = r_waddr;
   assign rf_wdata    = r_wdata;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit. Each table row is driven just after a
// rising edge and checked at the following falling edge: ld_ready/stall
// reflect the row's own inputs, the write port / ld_busy / ld_spurious
// reflect the state left by the previous rows.
module tb_writeback_unit;
   import wb_pkg::*;

   typedef struct {
      logic        av;
      logic [4:0]  ard;
      logic [31:0] ad;
      logic        li;
      logic [4:0]  lrd;
      logic        lv;
      logic [31:0] ldd;
      logic [4:0]  r1;
      logic [4:0]  r2;
      logic        e_we;
      logic [4:0]  e_wa;
      logic [31:0] e_wd;
      logic        e_stall;
      logic        e_busy;
      logic        e_ready;
      logic        e_spur;
   } row_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        alu_valid;
   reg_idx_t    alu_rd;
   logic [31:0] alu_data;
   logic        ld_issue;
   reg_idx_t    ld_issue_rd;
   logic        ld_valid;
   logic        ld_ready;
   logic [31:0] ld_data;
   reg_idx_t    rs1;
   reg_idx_t    rs2;
   logic        stall;
   logic        ld_busy;
   logic        ld_spurious;
   logic        rf_we;
   reg_idx_t    rf_waddr;
   logic [31:0] rf_wdata;
`ifdef WB_FORWARD_EN
   logic        fwd1_hit;
   logic        fwd2_hit;
   logic [31:0] fwd_data;
`endif

   int n_chk = 0;
   int n_err = 0;
   row_t tbl[$];

   always #5 clk = ~clk;

   writeback_unit #(
      .XLEN  (32),
      .NREGS (32)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .alu_valid   (alu_valid),
      .alu_rd      (alu_rd),
      .alu_data    (alu_data),
      .ld_issue    (ld_issue),
      .ld_issue_rd (ld_issue_rd),
      .ld_valid    (ld_valid),
      .ld_ready    (ld_ready),
      .ld_data     (ld_data),
      .rs1         (rs1),
      .rs2         (rs2),
      .stall       (stall),
      .ld_busy     (ld_busy),
      .ld_spurious (ld_spurious),
      .rf_we       (rf_we),
      .rf_waddr    (rf_waddr),
      .rf_wdata    (rf_wdata)
`ifdef WB_FORWARD_EN
      ,
      .fwd1_hit    (fwd1_hit),
      .fwd2_hit    (fwd2_hit),
      .fwd_data    (fwd_data)
`endif
   );

   function automatic row_t mk(
      input logic av, input logic [4:0] ard, input logic [31:0] ad,
      input logic li, input logic [4:0] lrd,
      input logic lv, input logic [31:0] ldd,
      input logic [4:0] r1, input logic [4:0] r2,
      input logic e_we, input logic [4:0] e_wa, input logic [31:0] e_wd,
      input logic e_stall, input logic e_busy, input logic e_ready,
      input logic e_spur);
      row_t r;
      r.av = av; r.ard = ard; r.ad = ad; r.li = li; r.lrd = lrd;
      r.lv = lv; r.ldd = ldd; r.r1 = r1; r.r2 = r2;
      r.e_we = e_we; r.e_wa = e_wa; r.e_wd = e_wd; r.e_stall = e_stall;
      r.e_busy = e_busy; r.e_ready = e_ready; r.e_spur = e_spur;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input row_t r);
      @(posedge clk);
      #1;
      alu_valid   = r.av;
      alu_rd      = r.ard;
      alu_data    = r.ad;
      ld_issue    = r.li;
      ld_issue_rd = r.lrd;
      ld_valid    = r.lv;
      ld_data     = r.ldd;
      rs1         = r.r1;
      rs2         = r.r2;
   endtask

   task automatic idle();
      drive(mk(0,0,0, 0,0, 0,0, 0,0, 0,0,0, 0,0,0,0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      // av ard ad | li lrd | lv ldd | r1 r2 || we wa wd | stall busy ready spur
      tbl.push_back(mk(1,5,32'hDEADBEEF, 0,0,  0,0,          0,0,   0,0,0,                0,0,0,0)); // 0
      tbl.push_back(mk(0,0,0,            0,0,  0,0,          0,0,   1,5,32'hDEADBEEF,     0,0,1,0)); // 1
      tbl.push_back(mk(0,0,0,            1,7,  0,0,          0,0,   0,0,0,                0,0,1,0)); // 2
      tbl.push_back(mk(0,0,0,            0,0,  0,0,          7,0,   0,0,0,                1,1,1,0)); // 3
      tbl.push_back(mk(0,0,0,            0,0,  1,32'h1234,   7,0,   0,0,0,                1,1,1,0)); // 4
      tbl.push_back(mk(0,0,0,            0,0,  0,0,          0,0,   1,7,32'h1234,         0,0,1,0)); // 5
      tbl.push_back(mk(0,0,0,            0,0,  0,0,          7,0,   0,0,0,                0,0,1,0)); // 6
      tbl.push_back(mk(0,0,0,            1,10, 0,0,          0,0,   0,0,0,                0,0,1,0)); // 7
      tbl.push_back(mk(1,4,32'hAAAA,     0,0,  1,32'hBBBB,   0,0,   0,0,0,                0,1,0,0)); // 8
      tbl.push_back(mk(0,0,0,            0,0,  1,32'hBBBB,   0,0,   1,4,32'hAAAA,         0,1,1,0)); // 9
      tbl.push_back(mk(0,0,0,            0,0,  0,0,          0,0,   1,10,32'hBBBB,        0,0,1,0)); // 10
      tbl.push_back(mk(0,0,0,            1,12, 0,0,          0,0,   0,0,0,                0,0,1,0)); // 11
      tbl.push_back(mk(1,12,32'h77,      0,0,  0,0,          0,0,   0,0,0,                1,1,0,0)); // 12
      tbl.push_back(mk(0,0,0,            0,0,  0,0,          0,12,  1,12,32'h77,          1,1,1,0)); // 13
      tbl.push_back(mk(0,0,0,            1,13, 0,0,          0,12,  0,0,0,                1,1,1,0)); // 14
      tbl.push_back(mk(0,0,0,            0,0,  1,32'h99,     0,13,  0,0,0,                0,1,1,0)); // 15
      tbl.push_back(mk(0,0,0,            0,0,  0,0,          0,0,   1,12,32'h99,          0,0,1,0)); // 16
      tbl.push_back(mk(0,0,0,            1,14, 0,0,          0,0,   0,0,0,                0,0,1,0)); // 17
      tbl.push_back(mk(0,0,0,            1,15, 1,32'h1111,   0,0,   0,0,0,                0,1,1,0)); // 18
      tbl.push_back(mk(0,0,0,            0,0,  0,0,          15,14, 1,14,32'h1111,        1,1,1,0)); // 19
      tbl.push_back(mk(0,0,0,            0,0,  1,32'h2222,   0,14,  0,0,0,                0,1,1,0)); // 20
      tbl.push_back(mk(0,0,0,            0,0,  0,0,          0,0,   1,15,32'h2222,        0,0,1,0)); // 21
      tbl.push_back(mk(0,0,0,            0,0,  1,32'h3333,   0,0,   0,0,0,                0,0,1,0)); // 22
      tbl.push_back(mk(1,0,32'h4444,     0,0,  0,0,          0,0,   0,0,0,                0,0,0,1)); // 23
      tbl.push_back(mk(0,0,0,            0,0,  0,0,          0,0,   0,0,0,                0,0,1,1)); // 24
      tbl.push_back(mk(0,0,0,            1,0,  0,0,          0,0,   0,0,0,                0,0,1,1)); // 25
      tbl.push_back(mk(0,0,0,            0,0,  1,32'h5555,   0,0,   0,0,0,                0,1,1,1)); // 26
      tbl.push_back(mk(0,0,0,            0,0,  0,0,          0,0,   0,0,0,                0,0,1,1)); // 27
      tbl.push_back(mk(0,0,0,            1,20, 0,0,          0,0,   0,0,0,                0,0,1,1)); // 28
      tbl.push_back(mk(0,0,0,            1,20, 1,32'h6666,   0,0,   0,0,0,                0,1,1,1)); // 29
      tbl.push_back(mk(0,0,0,            0,0,  0,0,          20,0,  1,20,32'h6666,        1,1,1,1)); // 30
      tbl.push_back(mk(0,0,0,            0,0,  1,32'h7777,   20,0,  0,0,0,                1,1,1,1)); // 31
      tbl.push_back(mk(0,0,0,            0,0,  0,0,          0,0,   1,20,32'h7777,        0,0,1,1)); // 32

      // Reset state
      reset = 1'b1;
      alu_valid = 0; alu_rd = 0; alu_data = 0; ld_issue = 0; ld_issue_rd = 0;
      ld_valid = 0; ld_data = 0; rs1 = 0; rs2 = 0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_we", rf_we, 0);
      chk("rst_waddr", rf_waddr, 0);
      chk("rst_wdata", rf_wdata, 0);
      chk("rst_busy", ld_busy, 0);
      chk("rst_spur", ld_spurious, 0);
      chk("rst_stall", stall, 0);
      chk("rst_ready", ld_ready, 1);

      foreach (tbl[i]) begin
         drive(tbl[i]);
         @(negedge clk);
         chk($sformatf("r%0d_we", i), rf_we, tbl[i].e_we);
         if (tbl[i].e_we) begin
            chk($sformatf("r%0d_waddr", i), rf_waddr, tbl[i].e_wa);
            chk($sformatf("r%0d_wdata", i), rf_wdata, tbl[i].e_wd);
         end
         chk($sformatf("r%0d_stall", i), stall, tbl[i].e_stall);
         chk($sformatf("r%0d_busy", i), ld_busy, tbl[i].e_busy);
         chk($sformatf("r%0d_ready", i), ld_ready, tbl[i].e_ready);
         chk($sformatf("r%0d_spur", i), ld_spurious, tbl[i].e_spur);
      end

      // Reset in the middle of a load for x3 abandons it
      drive(mk(0,0,0, 1,3, 0,0, 0,0, 0,0,0, 0,0,0,0));
      drive(mk(0,0,0, 0,0, 0,0, 3,0, 0,0,0, 0,0,0,0));
      @(negedge clk);
      chk("mid_busy", ld_busy, 1);
      chk("mid_stall", stall, 1);
      drive(mk(0,0,0, 0,0, 0,0, 3,0, 0,0,0, 0,0,0,0));
      reset = 1'b1;
      drive(mk(0,0,0, 0,0, 0,0, 3,0, 0,0,0, 0,0,0,0));
      reset = 1'b0;
      @(negedge clk);
      chk("rw_stall", stall, 0);
      chk("rw_busy", ld_busy, 0);
      chk("rw_we", rf_we, 0);
      chk("rw_waddr", rf_waddr, 0);
      chk("rw_wdata", rf_wdata, 0);
      chk("rw_spur", ld_spurious, 0);
      drive(mk(0,0,0, 0,0, 1,32'h8888, 3,0, 0,0,0, 0,0,0,0));
      @(negedge clk);
      chk("rw_late_ready", ld_ready, 1);
      chk("rw_late_stall", stall, 0);
      idle();
      @(negedge clk);
      chk("rw_late_we", rf_we, 0);
      chk("rw_late_spur", ld_spurious, 1);
      chk("rw_late_busy", ld_busy, 0);

      // In-flight write to x9 against rs2 in the next cycle
      drive(mk(1,9,32'h55, 0,0, 0,0, 0,0, 0,0,0, 0,0,0,0));
      drive(mk(0,0,0, 0,0, 0,0, 0,9, 0,0,0, 0,0,0,0));
      @(negedge clk);
      chk("fw_we", rf_we, 1);
      chk("fw_waddr", rf_waddr, 9);
      chk("fw_wdata", rf_wdata, 32'h55);
`ifdef WB_FORWARD_EN
      chk("fw_hit2", fwd2_hit, 1);
      chk("fw_hit1", fwd1_hit, 0);
      chk("fw_data", fwd_data, 32'h55);
      chk("fw_stall", stall, 0);
`else
      chk("fw_stall", stall, 1);
`endif
      idle();
      @(negedge clk);
      chk("fw_after_we", rf_we, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
